// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Phase sequencer for the multi-cycle datapath. It steps each
//             instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
//             waits on the memory-ready handshake, traps on illegal opcodes
//             or memory stalls, and counts retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_unit #(
    parameter bit ENABLE_UPPER   = 1'b1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 memReady,
    output logic [1:0]           jumpType,
    output logic [1:0]           ALUOp,
    output logic                 ALUSrc,
    output logic [1:0]           aluSrcA,
    output logic                 branch,
    output logic                 memRead,
    output logic                 memToReg,
    output logic                 memWrite,
    output logic                 regWrite,
    output logic                 irWrite,
    output logic                 pcWrite,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        c_ST_FETCH     = 3'd0,
        c_ST_DECODE    = 3'd1,
        c_ST_EXECUTE   = 3'd2,
        c_ST_MEMORY    = 3'd3,
        c_ST_WRITEBACK = 3'd4,
        c_ST_TRAP      = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        c_CLS_R     = 4'd0,
        c_CLS_IMM   = 4'd1,
        c_CLS_LOAD  = 4'd2,
        c_CLS_STORE = 4'd3,
        c_CLS_BR    = 4'd4,
        c_CLS_JALR  = 4'd5,
        c_CLS_JAL   = 4'd6,
        c_CLS_LUI   = 4'd7,
        c_CLS_AUIPC = 4'd8
    } class_t;

    // The wait counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int                c_WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit                c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
        c_WAIT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t                r_state_q,   w_state_d;
    class_t                r_class_q,   w_class_d;
    logic [c_WAIT_W-1:0]   r_wait_q,    w_wait_d;
    logic                  r_illegal_q, w_illegal_d;
    logic                  r_timeout_q, w_timeout_d;
    logic [CNT_WIDTH-1:0]  r_instret_q, w_instret_d;

    class_t                w_dec_class;
    logic                  w_legal;
    logic                  w_wait_expired;

    // Opcode decode into an instruction class; lui/auipc legal only when enabled.
    always_comb begin
        w_legal     = 1'b1;
        w_dec_class = c_CLS_R;
        case (opcode)
            7'b0110011: w_dec_class = c_CLS_R;
            7'b0010011: w_dec_class = c_CLS_IMM;
            7'b0000011: w_dec_class = c_CLS_LOAD;
            7'b0100011: w_dec_class = c_CLS_STORE;
            7'b1100011: w_dec_class = c_CLS_BR;
            7'b1100111: w_dec_class = c_CLS_JALR;
            7'b1101111: w_dec_class = c_CLS_JAL;
            7'b0110111: begin
                w_dec_class = c_CLS_LUI;
                w_legal     = ENABLE_UPPER;
            end
            7'b0010111: begin
                w_dec_class = c_CLS_AUIPC;
                w_legal     = ENABLE_UPPER;
            end
            default:    w_legal = 1'b0;
        endcase
    end

    // Next-state, trap causes, stall counter and retirement count.
    always_comb begin
        w_state_d      = r_state_q;
        w_class_d      = r_class_q;
        w_wait_d       = '0;
        w_illegal_d    = r_illegal_q;
        w_timeout_d    = r_timeout_q;
        w_wait_expired = c_TIMEOUT_EN && (r_wait_q == c_WAIT_LAST);
        w_instret_d    = pcWrite ? (r_instret_q + CNT_WIDTH'(1)) : r_instret_q;
        case (r_state_q)
            c_ST_FETCH: begin
                if (memReady) begin
                    w_state_d = c_ST_DECODE;
                end else if (w_wait_expired) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = c_ST_TRAP;
                end else begin
                    w_wait_d = r_wait_q + c_WAIT_W'(1);
                end
            end
            c_ST_DECODE: begin
                if (w_legal) begin
                    w_class_d = w_dec_class;
                    w_state_d = c_ST_EXECUTE;
                end else begin
                    w_illegal_d = 1'b1;
                    w_state_d   = c_ST_TRAP;
                end
            end
            c_ST_EXECUTE: begin
                case (r_class_q)
                    c_CLS_BR:                w_state_d = c_ST_FETCH;
                    c_CLS_LOAD, c_CLS_STORE: w_state_d = c_ST_MEMORY;
                    default:                 w_state_d = c_ST_WRITEBACK;
                endcase
            end
            c_ST_MEMORY: begin
                // A response on the last allowed wait cycle still completes normally.
                if (memReady) begin
                    w_state_d = (r_class_q == c_CLS_LOAD) ? c_ST_WRITEBACK : c_ST_FETCH;
                end else if (w_wait_expired) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = c_ST_TRAP;
                end else begin
                    w_wait_d = r_wait_q + c_WAIT_W'(1);
                end
            end
            c_ST_WRITEBACK: w_state_d = c_ST_FETCH;
            c_ST_TRAP:      w_state_d = c_ST_TRAP;
            default:        w_state_d = c_ST_FETCH;
        endcase
    end

    // Datapath controls decoded from the current phase and latched class.
    always_comb begin
        jumpType = 2'b00;
        ALUOp    = 2'b00;
        ALUSrc   = 1'b0;
        aluSrcA  = 2'b00;
        branch   = 1'b0;
        memRead  = 1'b0;
        memToReg = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        case (r_state_q)
            c_ST_FETCH: begin
                memRead = 1'b1;
                irWrite = memReady;
            end
            c_ST_EXECUTE, c_ST_MEMORY: begin
                // MEMORY keeps the EXECUTE ALU setup so the address stays stable.
                case (r_class_q)
                    c_CLS_R: ALUOp = 2'b10;
                    c_CLS_IMM, c_CLS_LOAD, c_CLS_STORE: ALUSrc = 1'b1;
                    c_CLS_LUI: begin
                        ALUSrc  = 1'b1;
                        aluSrcA = 2'b10;
                    end
                    c_CLS_AUIPC: begin
                        ALUSrc  = 1'b1;
                        aluSrcA = 2'b01;
                    end
                    c_CLS_JAL: begin
                        ALUOp    = 2'b11;
                        ALUSrc   = 1'b1;
                        jumpType = 2'b10;
                    end
                    c_CLS_JALR: begin
                        ALUOp    = 2'b11;
                        ALUSrc   = 1'b1;
                        jumpType = 2'b01;
                    end
                    c_CLS_BR: begin
                        ALUOp  = 2'b01;
                        branch = 1'b1;
                    end
                    default: ;
                endcase
                if (r_state_q == c_ST_EXECUTE) begin
                    pcWrite = (r_class_q == c_CLS_BR);
                end else if (r_class_q == c_CLS_LOAD) begin
                    memRead = 1'b1;
                end else if (r_class_q == c_CLS_STORE) begin
                    memWrite = 1'b1;
                    pcWrite  = memReady;
                end
            end
            c_ST_WRITEBACK: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                memToReg = (r_class_q == c_CLS_LOAD);
                if (r_class_q == c_CLS_JAL || r_class_q == c_CLS_JALR) begin
                    branch   = 1'b1;
                    jumpType = (r_class_q == c_CLS_JAL) ? 2'b10 : 2'b01;
                    aluSrcA  = 2'b01;
                end
            end
            default: ;
        endcase
        // Architectural writes must not leak out while reset is held.
        if (rst) begin
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            regWrite = 1'b0;
            memWrite = 1'b0;
        end
    end

    // State, class, counters and sticky trap flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_ST_FETCH;
            r_class_q   <= c_CLS_R;
            r_wait_q    <= '0;
            r_illegal_q <= 1'b0;
            r_timeout_q <= 1'b0;
            r_instret_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_class_q   <= w_class_d;
            r_wait_q    <= w_wait_d;
            r_illegal_q <= w_illegal_d;
            r_timeout_q <= w_timeout_d;
            r_instret_q <= w_instret_d;
        end
    end

    assign state   = r_state_q;
    assign illegal = r_illegal_q;
    assign timeout = r_timeout_q;
    assign instret = r_instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_unit
//  Purpose  : Directed scoreboard bench for multicycle_control_unit. Two
//             instances: A (no lui/auipc, 4-cycle timeout, 32-bit count) and
//             B (lui/auipc, timeout off, 2-bit count to show wrap).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control_unit;

    // Opcodes
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    // Control vector: jumpType ALUOp ALUSrc aluSrcA branch memRead memToReg memWrite regWrite irWrite pcWrite illegal timeout
    localparam logic [15:0] K_FW    = 16'b00_00_0_00_0_1_0_0_0_0_0_0_0;
    localparam logic [15:0] K_FR    = 16'b00_00_0_00_0_1_0_0_0_1_0_0_0;
    localparam logic [15:0] K_DEC   = 16'b00_00_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] K_EXR   = 16'b00_10_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] K_EXI   = 16'b00_00_1_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] K_MLD   = 16'b00_00_1_00_0_1_0_0_0_0_0_0_0;
    localparam logic [15:0] K_MST   = 16'b00_00_1_00_0_0_0_1_0_0_0_0_0;
    localparam logic [15:0] K_WB    = 16'b00_00_0_00_0_0_0_0_1_0_1_0_0;
    localparam logic [15:0] K_WLD   = 16'b00_00_0_00_0_0_1_0_1_0_1_0_0;
    localparam logic [15:0] K_EXJAL = 16'b10_11_1_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] K_WJAL  = 16'b10_00_0_01_1_0_0_0_1_0_1_0_0;
    localparam logic [15:0] K_EXJR  = 16'b01_11_1_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] K_WJR   = 16'b01_00_0_01_1_0_0_0_1_0_1_0_0;
    localparam logic [15:0] K_EXBR  = 16'b00_01_0_00_1_0_0_0_0_0_1_0_0;
    localparam logic [15:0] K_EXLUI = 16'b00_00_1_10_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] K_EXAUI = 16'b00_00_1_01_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] K_TO    = 16'b00_00_0_00_0_0_0_0_0_0_0_0_1;
    localparam logic [15:0] K_IL    = 16'b00_00_0_00_0_0_0_0_0_0_0_1_0;

    logic clk;
    logic rst_a, rdy_a, rst_b, rdy_b;
    logic [6:0] op_a, op_b;

    logic [1:0] jt_a, aop_a, asa_a, jt_b, aop_b, asa_b;
    logic       bs_a, br_a, mr_a, mtr_a, mw_a, rw_a, ir_a, pw_a, il_a, to_a;
    logic       bs_b, br_b, mr_b, mtr_b, mw_b, rw_b, ir_b, pw_b, il_b, to_b;
    logic [2:0] st_a, st_b;
    logic [31:0] inst_a;
    logic [1:0]  inst_b;

    multicycle_control_unit #(.ENABLE_UPPER(1'b0), .TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst_a), .opcode(op_a), .memReady(rdy_a),
        .jumpType(jt_a), .ALUOp(aop_a), .ALUSrc(bs_a), .aluSrcA(asa_a),
        .branch(br_a), .memRead(mr_a), .memToReg(mtr_a), .memWrite(mw_a),
        .regWrite(rw_a), .irWrite(ir_a), .pcWrite(pw_a), .state(st_a),
        .illegal(il_a), .timeout(to_a), .instret(inst_a)
    );

    multicycle_control_unit #(.ENABLE_UPPER(1'b1), .TIMEOUT_CYCLES(0), .CNT_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .opcode(op_b), .memReady(rdy_b),
        .jumpType(jt_b), .ALUOp(aop_b), .ALUSrc(bs_b), .aluSrcA(asa_b),
        .branch(br_b), .memRead(mr_b), .memToReg(mtr_b), .memWrite(mw_b),
        .regWrite(rw_b), .irWrite(ir_b), .pcWrite(pw_b), .state(st_b),
        .illegal(il_b), .timeout(to_b), .instret(inst_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sel;
        logic [2:0]  st;
        logic [15:0] ctrl;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle of inputs on the selected instance and queue its expected outputs.
    task automatic cyc(input string nm, input bit s, input logic r, input logic [6:0] op,
                       input logic rdy, input logic [2:0] st, input logic [15:0] ctrl,
                       input logic [31:0] inst);
        exp_t e;
        if (s == 1'b0) begin
            rst_a = r; op_a = op; rdy_a = rdy;
        end else begin
            rst_b = r; op_b = op; rdy_b = rdy;
        end
        e.name = nm; e.sel = s; e.st = st; e.ctrl = ctrl; e.inst = inst;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the oldest expectation against the live outputs mid-cycle.
    exp_t        m_e;
    logic [2:0]  m_st;
    logic [15:0] m_ctrl;
    logic [31:0] m_inst;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            if (m_e.sel == 1'b0) begin
                m_st   = st_a;
                m_ctrl = {jt_a, aop_a, bs_a, asa_a, br_a, mr_a, mtr_a, mw_a, rw_a, ir_a, pw_a, il_a, to_a};
                m_inst = inst_a;
            end else begin
                m_st   = st_b;
                m_ctrl = {jt_b, aop_b, bs_b, asa_b, br_b, mr_b, mtr_b, mw_b, rw_b, ir_b, pw_b, il_b, to_b};
                m_inst = {30'd0, inst_b};
            end
            checks++;
            if (m_st !== m_e.st) begin
                errors++;
                $display("FAIL %s state got %0d want %0d", m_e.name, m_st, m_e.st);
            end
            checks++;
            if (m_ctrl !== m_e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got %b want %b", m_e.name, m_ctrl, m_e.ctrl);
            end
            checks++;
            if (m_inst !== m_e.inst) begin
                errors++;
                $display("FAIL %s instret got %0d want %0d", m_e.name, m_inst, m_e.inst);
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; op_a = '0; op_b = '0; rdy_a = 1'b0; rdy_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- instance A ----------------
        cyc("a_rst",     0, 1, OP_R,  1, 3'd0, K_FW,  0);
        cyc("r_fetch",   0, 0, OP_R,  1, 3'd0, K_FR,  0);
        cyc("r_decode",  0, 0, OP_R,  1, 3'd1, K_DEC, 0);
        cyc("r_exec",    0, 0, OP_R,  1, 3'd2, K_EXR, 0);
        cyc("r_wb",      0, 0, OP_R,  1, 3'd4, K_WB,  0);

        cyc("ld_fetch",  0, 0, OP_LD, 1, 3'd0, K_FR,  1);
        cyc("ld_decode", 0, 0, OP_LD, 1, 3'd1, K_DEC, 1);
        cyc("ld_exec",   0, 0, OP_LD, 1, 3'd2, K_EXI, 1);
        for (int i = 0; i < 3; i++) cyc("ld_memwait", 0, 0, OP_LD, 0, 3'd3, K_MLD, 1);
        cyc("ld_memrdy", 0, 0, OP_LD, 1, 3'd3, K_MLD, 1);
        cyc("ld_wb",     0, 0, OP_LD, 1, 3'd4, K_WLD, 1);

        cyc("jal_fetch", 0, 0, OP_JAL, 1, 3'd0, K_FR,    2);
        cyc("jal_dec",   0, 0, OP_JAL, 1, 3'd1, K_DEC,   2);
        cyc("jal_exec",  0, 0, OP_JAL, 1, 3'd2, K_EXJAL, 2);
        cyc("jal_wb",    0, 0, OP_JAL, 1, 3'd4, K_WJAL,  2);

        cyc("br_fetch",  0, 0, OP_BR, 1, 3'd0, K_FR,   3);
        cyc("br_dec",    0, 0, OP_BR, 1, 3'd1, K_DEC,  3);
        cyc("br_exec",   0, 0, OP_BR, 1, 3'd2, K_EXBR, 3);

        cyc("st_fetch",  0, 0, OP_ST, 1, 3'd0, K_FR,  4);
        cyc("st_dec",    0, 0, OP_ST, 1, 3'd1, K_DEC, 4);
        cyc("st_exec",   0, 0, OP_ST, 1, 3'd2, K_EXI, 4);
        cyc("st_memwait",0, 0, OP_ST, 0, 3'd3, K_MST, 4);
        cyc("st_rstmem", 0, 1, OP_ST, 1, 3'd3, K_EXI, 4);
        cyc("st_postrst",0, 0, OP_ST, 0, 3'd0, K_FW,  0);

        for (int i = 0; i < 3; i++) cyc("to_fetchwait", 0, 0, OP_R, 0, 3'd0, K_FW, 0);
        for (int i = 0; i < 2; i++) cyc("to_trap",      0, 0, OP_R, 1, 3'd5, K_TO, 0);
        cyc("to_rst",    0, 1, OP_R, 0, 3'd5, K_TO, 0);

        for (int i = 0; i < 3; i++) cyc("tl_fetchwait", 0, 0, OP_LUI, 0, 3'd0, K_FW, 0);
        cyc("tl_lastrdy",0, 0, OP_LUI, 1, 3'd0, K_FR,  0);
        cyc("il_decode", 0, 0, OP_LUI, 1, 3'd1, K_DEC, 0);
        for (int i = 0; i < 10; i++) cyc("il_trap", 0, 0, OP_LUI, 1, 3'd5, K_IL, 0);
        cyc("il_rst",    0, 1, OP_LUI, 1, 3'd5, K_IL, 0);

        cyc("imm_fetch", 0, 0, OP_IMM, 1, 3'd0, K_FR,  0);
        cyc("imm_dec",   0, 0, OP_IMM, 1, 3'd1, K_DEC, 0);
        cyc("imm_exec",  0, 0, OP_IMM, 1, 3'd2, K_EXI, 0);
        cyc("imm_wb",    0, 0, OP_IMM, 1, 3'd4, K_WB,  0);
        cyc("imm_next",  0, 0, OP_IMM, 1, 3'd0, K_FR,  1);
        rst_a = 1'b1;

        // ---------------- instance B ----------------
        cyc("b_rst",     1, 1, OP_LUI, 0, 3'd0, K_FW,    0);
        cyc("lui_fetch", 1, 0, OP_LUI, 1, 3'd0, K_FR,    0);
        cyc("lui_dec",   1, 0, OP_LUI, 1, 3'd1, K_DEC,   0);
        cyc("lui_exec",  1, 0, OP_LUI, 1, 3'd2, K_EXLUI, 0);
        cyc("lui_wb",    1, 0, OP_LUI, 1, 3'd4, K_WB,    0);
        cyc("aui_fetch", 1, 0, OP_AUI, 1, 3'd0, K_FR,    1);
        cyc("aui_dec",   1, 0, OP_AUI, 1, 3'd1, K_DEC,   1);
        cyc("aui_exec",  1, 0, OP_AUI, 1, 3'd2, K_EXAUI, 1);
        cyc("aui_wb",    1, 0, OP_AUI, 1, 3'd4, K_WB,    1);
        for (int i = 0; i < 20; i++) cyc("nto_fetchwait", 1, 0, OP_BR, 0, 3'd0, K_FW, 2);
        cyc("br1_fetch", 1, 0, OP_BR, 1, 3'd0, K_FR,   2);
        cyc("br1_dec",   1, 0, OP_BR, 1, 3'd1, K_DEC,  2);
        cyc("br1_exec",  1, 0, OP_BR, 1, 3'd2, K_EXBR, 2);
        cyc("br2_fetch", 1, 0, OP_BR, 1, 3'd0, K_FR,   3);
        cyc("br2_dec",   1, 0, OP_BR, 1, 3'd1, K_DEC,  3);
        cyc("br2_exec",  1, 0, OP_BR, 1, 3'd2, K_EXBR, 3);
        cyc("jr_wrapfetch", 1, 0, OP_JALR, 1, 3'd0, K_FR,   0);
        cyc("jr_dec",    1, 0, OP_JALR, 1, 3'd1, K_DEC,  0);
        cyc("jr_exec",   1, 0, OP_JALR, 1, 3'd2, K_EXJR, 0);
        cyc("jr_wb",     1, 0, OP_JALR, 1, 3'd4, K_WJR,  0);
        cyc("jr_next",   1, 0, OP_JALR, 1, 3'd0, K_FR,   1);
        rst_b = 1'b1;

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing controller for the multi-cycle datapath. Walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and waits on a memory-ready handshake. It drives the existing datapath control set (jumpType, ALUOp, ALUSrc, branch, memRead, memToReg, memWrite, regWrite) one phase at a time, plus irWrite, pcWrite and aluSrcA. It adds optional lui/auipc support, illegal-opcode and memory-timeout trapping, and a retired-instruction counter.

## Interface
- ENABLE_UPPER, 1: 1 decodes lui (0110111) and auipc (0010111); 0 treats them as illegal
- TIMEOUT_CYCLES, 16: maximum memReady wait cycles in FETCH/MEMORY; 0 disables the timeout
- CNT_WIDTH, 32: width of instret
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- opcode  in  7  instruction-register opcode, sampled in DECODE
- memReady  in  1  memory completes the current request this cycle
- jumpType  out  2  01 jalr, 10 jal, else 00
- ALUOp  out  2  10 R-type, 01 branch, 11 jal/jalr, 00 otherwise
- ALUSrc  out  1  ALU operand B: 1 immediate, 0 rs2
- aluSrcA  out  2  ALU operand A: 00 rs1, 01 PC, 10 zero
- branch, memRead, memToReg, memWrite, regWrite  out  1 each  datapath strobes
- irWrite  out  1  load instruction register
- pcWrite  out  1  load PC (target chosen by datapath from branch/jumpType)
- state  out  3  0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK, 5 TRAP
- illegal, timeout  out  1 each  sticky trap causes
- instret  out  CNT_WIDTH  retired-instruction count

## Operation
- Registers: state, class (decoded in DECODE), wait counter, illegal, timeout, instret. All other outputs are combinational from state, class and memReady.
- Classes: R (0110011), IMM (0010011), LOAD (0000011), STORE (0100011), BR (1100011), JALR (1100111), JAL (1101111), LUI and AUIPC (only when ENABLE_UPPER=1).
- FETCH
  - memRead=1.
  - On memReady: irWrite=1, go to DECODE.
- DECODE
  - Legal opcode: latch class, go to EXECUTE.
  - Illegal opcode: set illegal, go to TRAP.
- EXECUTE
  - R: ALUOp=10, ALUSrc=0.
  - IMM/LOAD/STORE: ALUOp=00, ALUSrc=1.
  - LUI: ALUSrc=1, aluSrcA=10.
  - AUIPC: ALUSrc=1, aluSrcA=01.
  - JAL/JALR: ALUOp=11, ALUSrc=1, jumpType per class.
  - BR: ALUOp=01, branch=1, pcWrite=1, go to FETCH.
  - LOAD/STORE go to MEMORY; all other classes go to WRITEBACK.
- MEMORY
  - ALU controls held from EXECUTE.
  - LOAD: memRead=1. On memReady, go to WRITEBACK.
  - STORE: memWrite=1. On memReady, pcWrite=1 and go to FETCH.
- WRITEBACK
  - regWrite=1 and pcWrite=1 for exactly one cycle.
  - LOAD: memToReg=1.
  - JAL/JALR: branch=1, jumpType held, aluSrcA=01 for the link value.
  - Go to FETCH.
- TRAP: all strobes 0, state held until rst.
- instret increments by 1 on every cycle with pcWrite=1 and wraps modulo 2^CNT_WIDTH.
- Timeout
  - Wait counter clears on entry to FETCH/MEMORY and increments each cycle there without memReady.
  - If TIMEOUT_CYCLES>0 and the TIMEOUT_CYCLES-th consecutive wait cycle also lacks memReady: set timeout, go to TRAP.
  - memReady on that final cycle wins (normal advance).
- memReady outside FETCH/MEMORY is ignored.

## Timing
- Reset
  - After the rst edge: state=FETCH, class, counter, illegal, timeout and instret all 0.
  - While rst=1, irWrite, pcWrite, regWrite and memWrite are forced to 0 in the same cycle, including a reset asserted mid-MEMORY or mid-WRITEBACK.
  - First cycle after reset: memRead=1 (FETCH).
- Latency with memReady=1 on the first request cycle:
  - BR: 3 cycles.
  - R/IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each extra wait cycle adds 1.
- irWrite and the MEMORY-exit transitions are same-cycle responses to memReady; the state advances on the next edge.
- pcWrite is asserted exactly once per retired instruction; instret updates on that same edge.

## Test plan
- Reset, then R-type 0110011, memReady tied 1:
  - states 0,1,2,4,0
  - ALUOp=10 in EXECUTE
  - regWrite=1 and pcWrite=1 in cycle 4
  - instret=1
- LOAD, memReady low 3 cycles in MEMORY:
  - memRead held 4 cycles
  - memToReg=1 with regWrite in WRITEBACK
  - total 8 cycles
- JAL, then BR:
  - JAL: jumpType=10, branch=1 in WRITEBACK
  - BR: pcWrite in EXECUTE, regWrite never asserted
  - instret=2
- ENABLE_UPPER=0 with opcode 0110111:
  - DECODE goes to TRAP, illegal=1
  - all strobes 0 for 10 further cycles
  - rst clears illegal and returns to FETCH
- TIMEOUT_CYCLES=4, memReady never in FETCH:
  - TRAP after 4 FETCH cycles, timeout=1
  - repeat with memReady on the 4th cycle: DECODE, no trap
- STORE with rst asserted during MEMORY:
  - memWrite=0 in the rst cycle
  - state=0 next cycle, instret=0
